div_issue_ctrl: RTL and testbench
=================================

Name: div_issue_ctrl

Overview:
Initiator side of the iterative divider interface. Sits in the EX stage between the decoded DIV/DIVU request and the divider wrapper. It latches the operands and drives a held start level to the divider. It stalls the pipeline while the divider runs, captures the 64-bit {remainder, quotient} result on done, and holds that result until the pipeline accepts it. It also handles flush and divide-by-zero, and runs a watchdog on the done pulse.

Parameters:
DIV_CYCLES, 36, nominal divider latency in cycles; must equal the divider's setting
WDOG_CYCLES, 48, busy cycles with no div_done before div_timeout sets; must exceed DIV_CYCLES+2

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  1  EX presents a DIV/DIVU this cycle
req_signed  input  1  1 = DIV (signed), 0 = DIVU
req_opa  input  32  dividend (rs)
req_opb  input  32  divisor (rt)
flush  input  1  exception/ERET cancel; kills any operation in flight
res_accept  input  1  pipeline consumes the result this cycle (HI/LO write)
stall_req  output  1  pipeline must hold EX
div_start  output  1  level start to the divider
div_unsigned  output  1  to the divider's flag_unsigned
div_operand1  output  32  registered dividend
div_operand2  output  32  registered divisor
div_result  input  64  {remainder, quotient} from the divider
div_done  input  1  divider completion, one-cycle
res_valid  output  1  result_hi/result_lo are valid
result_hi  output  32  remainder -> HI
result_lo  output  32  quotient -> LO
div_timeout  output  1  sticky watchdog error

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; operand and result regs 0; counter 0.
- States: IDLE, START_GAP, BUSY, HOLD.
- IDLE:
  - req_valid & !flush & req_opb!=0: latch operands and signedness; go to BUSY next cycle.
  - req_valid & !flush & req_opb==0: skip the divider; go to HOLD with result_hi=req_opa, result_lo=32'hFFFF_FFFF.
  - stall_req=req_valid & !flush (combinational) in the request cycle.
- BUSY:
  - div_start=1, with operands held stable from registers.
  - Counter increments each cycle.
  - On the edge sampling div_done=1: capture div_result, deassert div_start next cycle, go to HOLD.
  - Counter reaching WDOG_CYCLES sets div_timeout (sticky until reset); the state stays BUSY.
- HOLD:
  - res_valid=1; result regs stable.
  - res_accept=1: go to START_GAP.
  - While waiting, stall_req=1 until the cycle res_accept is seen; stall_req=0 in that cycle.
- START_GAP: exactly one cycle with div_start=0, then IDLE. This guarantees start is low for at least one cycle between operations, because the divider re-arms whenever start stays high.
- stall_req is 1 in BUSY and START_GAP.
- flush has priority in every state:
  - Next state is START_GAP; div_start drops the next cycle; res_valid clears; the result is discarded.
  - A req_valid in the same cycle as flush is ignored.
- div_done outside BUSY is ignored.
- div_unsigned = !latched req_signed.
- Result width: result_hi=div_result[63:32], result_lo=div_result[31:0]; no sign fixup here.
- Latency, req to res_valid: nominally DIV_CYCLES+2 cycles. The block keys only on div_done, never on the counter.

Decomposition:
- Shared defines header:
  - state encodings DIVC_IDLE, DIVC_START_GAP, DIVC_BUSY, DIVC_HOLD;
  - DIV_BY_ZERO_LO = 32'hFFFF_FFFF;
  - the existing reset-level macro, redefined for active-low use.
- Single module; no sub-module needed. The bench pairs it with the real divider wrapper.

Test Plan:
- DIVU 100/7 -> div_start held high until done; res_valid with hi=2, lo=14; stall_req drops in the res_accept cycle; div_start low for ≥1 cycle afterwards.
- DIV -7/2 signed -> hi=32'hFFFF_FFFF (-1), lo=32'hFFFF_FFFD (-3); div_unsigned=0 throughout BUSY.
- DIV 5/0 -> div_start never asserts; res_valid the next cycle with hi=5, lo=32'hFFFF_FFFF.
- flush 10 cycles into BUSY -> div_start=0 the next cycle; no res_valid; a new DIVU 9/3 issued afterwards returns lo=3, hi=0.
- res_accept held low for 5 cycles in HOLD -> result and res_valid stable; stall_req=1 throughout; a stray div_done is ignored.
- Divider stub that never asserts done -> div_timeout=1 at counter WDOG_CYCLES and stays set until reset; async reset mid-BUSY clears every output immediately.

Source files
------------

// File: rtl/div_issue_ctrl_pkg.sv
// Shared types and constants for the EX-stage divider issue controller.
package div_issue_ctrl_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned RES_W = 2 * XLEN;

   // Level of the reset input that holds the block in reset
   localparam logic RST_ACTIVE = 1'b0;

   // Quotient returned for a zero divisor; remainder is the dividend
   localparam logic [XLEN-1:0] DIV_BY_ZERO_LO = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      DIVC_IDLE      = 2'd0,
      DIVC_START_GAP = 2'd1,
      DIVC_BUSY      = 2'd2,
      DIVC_HOLD      = 2'd3
   } divc_state_e;

   // Divider result as it arrives on div_result: {remainder, quotient}
   typedef struct packed {
      logic [XLEN-1:0] hi;
      logic [XLEN-1:0] lo;
   } div_res_t;

endpackage

// File: rtl/div_issue_ctrl.sv
// Initiator side of the iterative divider: latches operands, holds start,
// stalls EX while busy and holds the {rem, quot} result until accepted.
module div_issue_ctrl
   import div_issue_ctrl_pkg::*;
#(
   parameter int unsigned DIV_CYCLES  = 36,
   parameter int unsigned WDOG_CYCLES = 48
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req_valid,
   input  logic             req_signed,
   input  logic [XLEN-1:0]  req_opa,
   input  logic [XLEN-1:0]  req_opb,
   input  logic             flush,
   input  logic             res_accept,
   output logic             stall_req,
   output logic             div_start,
   output logic             div_unsigned,
   output logic [XLEN-1:0]  div_operand1,
   output logic [XLEN-1:0]  div_operand2,
   input  logic [RES_W-1:0] div_result,
   input  logic             div_done,
   output logic             res_valid,
   output logic [XLEN-1:0]  result_hi,
   output logic [XLEN-1:0]  result_lo,
   output logic             div_timeout
);

   // A watchdog shorter than a nominal divide would fire on healthy operations
   localparam int unsigned WDOG_LIMIT = (WDOG_CYCLES > DIV_CYCLES + 2) ?
                                        WDOG_CYCLES : DIV_CYCLES + 3;
   localparam int unsigned CNT_W      = $clog2(WDOG_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WDOG_LIMIT);

   divc_state_e      state_q, state_d;
   logic [XLEN-1:0]  op_a_q, op_a_d;
   logic [XLEN-1:0]  op_b_q, op_b_d;
   logic             unsigned_q, unsigned_d;
   logic             start_q, start_d;
   logic             res_valid_q, res_valid_d;
   div_res_t         res_q, res_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;

   // Next-state, datapath capture and combinational stall
   always_comb begin
      state_d     = state_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      unsigned_d  = unsigned_q;
      res_d       = res_q;
      cnt_d       = '0;
      timeout_d   = timeout_q;
      stall_req   = 1'b0;

      unique case (state_q)
         DIVC_IDLE: begin
            if (req_valid && !flush) begin
               stall_req = 1'b1;
               if (req_opb == '0) begin
                  res_d   = '{hi: req_opa, lo: DIV_BY_ZERO_LO};
                  state_d = DIVC_HOLD;
               end else begin
                  op_a_d     = req_opa;
                  op_b_d     = req_opb;
                  unsigned_d = !req_signed;
                  state_d    = DIVC_BUSY;
               end
            end
         end
         DIVC_BUSY: begin
            stall_req = 1'b1;
            cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            if (cnt_d == CNT_MAX) begin
               timeout_d = 1'b1;
            end
            // Completion is taken from div_done only; the counter is a watchdog
            if (div_done) begin
               res_d   = div_res_t'(div_result);
               state_d = DIVC_HOLD;
            end
         end
         DIVC_HOLD: begin
            stall_req = !res_accept;
            if (res_accept) begin
               state_d = DIVC_START_GAP;
            end
         end
         DIVC_START_GAP: begin
            stall_req = 1'b1;
            state_d   = DIVC_IDLE;
         end
         default: begin
            state_d = DIVC_IDLE;
         end
      endcase

      // Cancel overrides everything; any captured or pending result is dropped
      if (flush) begin
         state_d = DIVC_START_GAP;
         res_d   = res_q;
         cnt_d   = '0;
      end

      start_d     = (state_d == DIVC_BUSY);
      res_valid_d = (state_d == DIVC_HOLD);
   end

   // State and datapath registers
   always_ff @(posedge clock or negedge reset) begin
      if (reset == RST_ACTIVE) begin
         state_q     <= DIVC_IDLE;
         op_a_q      <= '0;
         op_b_q      <= '0;
         unsigned_q  <= 1'b0;
         start_q     <= 1'b0;
         res_valid_q <= 1'b0;
         res_q       <= '0;
         cnt_q       <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         unsigned_q  <= unsigned_d;
         start_q     <= start_d;
         res_valid_q <= res_valid_d;
         res_q       <= res_d;
         cnt_q       <= cnt_d;
         timeout_q   <= timeout_d;
      end
   end

   assign div_start    = start_q;
   assign div_unsigned = unsigned_q;
   assign div_operand1 = op_a_q;
   assign div_operand2 = op_b_q;
   assign res_valid    = res_valid_q;
   assign result_hi    = res_q.hi;
   assign result_lo    = res_q.lo;
   assign div_timeout  = timeout_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl driving a behavioural divider stub.
module tb_div_issue_ctrl;

   localparam int unsigned DIV_CYCLES  = 36;
   localparam int unsigned WDOG_CYCLES = 48;

   logic        clock;
   logic        reset;
   logic        req_valid;
   logic        req_signed;
   logic [31:0] req_opa;
   logic [31:0] req_opb;
   logic        flush;
   logic        res_accept;
   logic        stall_req;
   logic        div_start;
   logic        div_unsigned;
   logic [31:0] div_operand1;
   logic [31:0] div_operand2;
   logic [63:0] div_result;
   logic        div_done;
   logic        res_valid;
   logic [31:0] result_hi;
   logic [31:0] result_lo;
   logic        div_timeout;

   int n_checks;
   int n_fail;

   div_issue_ctrl #(
      .DIV_CYCLES  (DIV_CYCLES),
      .WDOG_CYCLES (WDOG_CYCLES)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_signed   (req_signed),
      .req_opa      (req_opa),
      .req_opb      (req_opb),
      .flush        (flush),
      .res_accept   (res_accept),
      .stall_req    (stall_req),
      .div_start    (div_start),
      .div_unsigned (div_unsigned),
      .div_operand1 (div_operand1),
      .div_operand2 (div_operand2),
      .div_result   (div_result),
      .div_done     (div_done),
      .res_valid    (res_valid),
      .result_hi    (result_hi),
      .result_lo    (result_lo),
      .div_timeout  (div_timeout)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Divider stub: counts while start is high, pulses done once, re-arms on start low
   logic        stub_done;
   logic        stub_armed;
   logic        stub_dead;
   int          stub_cnt;
   logic [63:0] stub_res;
   logic        inj_done;
   logic [63:0] inj_res;

   function automatic logic [63:0] model_div(input logic [31:0] a, input logic [31:0] b,
                                             input logic uns);
      if (b == 32'd0) return 64'd0;
      if (uns) return {a % b, a / b};
      return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
   endfunction

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         stub_cnt   <= 0;
         stub_armed <= 1'b1;
         stub_done  <= 1'b0;
         stub_res   <= 64'd0;
      end else begin
         stub_done <= 1'b0;
         if (!div_start) begin
            stub_cnt   <= 0;
            stub_armed <= 1'b1;
         end else if (stub_armed) begin
            if (stub_cnt == int'(DIV_CYCLES) - 1) begin
               stub_cnt   <= 0;
               stub_armed <= 1'b0;
               if (!stub_dead) begin
                  stub_done <= 1'b1;
                  stub_res  <= model_div(div_operand1, div_operand2, div_unsigned);
               end
            end else begin
               stub_cnt <= stub_cnt + 1;
            end
         end
      end
   end

   assign div_done   = stub_done | inj_done;
   assign div_result = inj_done ? inj_res : stub_res;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Presents a request for one cycle; returns at the first negedge after it
   task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      req_valid  = 1'b1;
      req_signed = sgn;
      req_opa    = a;
      req_opb    = b;
      #1;
      check("req_stall", 64'(stall_req), 64'd1);
      @(negedge clock);
      req_valid = 1'b0;
   endtask

   // Waits for res_valid, watching start and the unsigned flag while busy
   task automatic wait_res(input string tag, input logic exp_uns,
                           output bit start_drop, output bit uns_bad);
      int cyc;
      cyc        = 0;
      start_drop = 1'b0;
      uns_bad    = 1'b0;
      while (!res_valid && cyc < 200) begin
         if (!div_start) start_drop = 1'b1;
         if (div_unsigned !== exp_uns) uns_bad = 1'b1;
         if (!stall_req) start_drop = 1'b1;
         @(negedge clock);
         cyc++;
      end
      check({tag, "_res_valid"}, 64'(res_valid), 64'd1);
   endtask

   task automatic accept(input string tag);
      res_accept = 1'b1;
      #1;
      check({tag, "_acc_stall"}, 64'(stall_req), 64'd0);
      @(negedge clock);
      res_accept = 1'b0;
      #1;
      check({tag, "_gap_start"}, 64'(div_start), 64'd0);
      check({tag, "_gap_valid"}, 64'(res_valid), 64'd0);
      check({tag, "_gap_stall"}, 64'(stall_req), 64'd1);
      @(negedge clock);
      #1;
      check({tag, "_idle_stall"}, 64'(stall_req), 64'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_stall"}, 64'(stall_req), 64'd0);
      check({tag, "_start"}, 64'(div_start), 64'd0);
      check({tag, "_uns"}, 64'(div_unsigned), 64'd0);
      check({tag, "_ops"}, {div_operand1, div_operand2}, 64'd0);
      check({tag, "_valid"}, 64'(res_valid), 64'd0);
      check({tag, "_res"}, {result_hi, result_lo}, 64'd0);
      check({tag, "_tmo"}, 64'(div_timeout), 64'd0);
   endtask

   initial begin
      bit drop;
      bit ubad;
      bit seen;
      int c;
      n_checks   = 0;
      n_fail     = 0;
      reset      = 1'b0;
      req_valid  = 1'b0;
      req_signed = 1'b0;
      req_opa    = 32'd0;
      req_opb    = 32'd0;
      flush      = 1'b0;
      res_accept = 1'b0;
      stub_dead  = 1'b0;
      inj_done   = 1'b0;
      inj_res    = 64'd0;

      repeat (3) @(negedge clock);
      #1;
      check_all_zero("rst");
      reset = 1'b1;
      @(negedge clock);

      // DIVU 100/7
      issue(1'b0, 32'd100, 32'd7);
      check("divu_start", 64'(div_start), 64'd1);
      check("divu_ops", {div_operand1, div_operand2}, {32'd100, 32'd7});
      wait_res("divu", 1'b1, drop, ubad);
      check("divu_start_held", 64'(drop), 64'd0);
      check("divu_uns", 64'(ubad), 64'd0);
      check("divu_res", {result_hi, result_lo}, {32'd2, 32'd14});
      check("divu_start_off", 64'(div_start), 64'd0);
      check("divu_hold_stall", 64'(stall_req), 64'd1);
      accept("divu");

      // DIV -7/2
      issue(1'b1, 32'hFFFF_FFF9, 32'd2);
      wait_res("div", 1'b0, drop, ubad);
      check("div_start_held", 64'(drop), 64'd0);
      check("div_uns", 64'(ubad), 64'd0);
      check("div_res", {result_hi, result_lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      accept("div");

      // DIV 5/0 bypasses the divider
      issue(1'b1, 32'd5, 32'd0);
      check("dz_start", 64'(div_start), 64'd0);
      check("dz_valid", 64'(res_valid), 64'd1);
      check("dz_res", {result_hi, result_lo}, {32'd5, 32'hFFFF_FFFF});
      accept("dz");

      // Request coincident with flush is dropped
      req_valid = 1'b1;
      req_opa   = 32'd50;
      req_opb   = 32'd5;
      flush     = 1'b1;
      #1;
      check("fr_stall", 64'(stall_req), 64'd0);
      @(negedge clock);
      req_valid = 1'b0;
      flush     = 1'b0;
      check("fr_start", 64'(div_start), 64'd0);
      check("fr_valid", 64'(res_valid), 64'd0);
      @(negedge clock);

      // Flush 10 cycles into BUSY
      issue(1'b0, 32'd1000, 32'd3);
      repeat (10) @(negedge clock);
      check("fl_busy_start", 64'(div_start), 64'd1);
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      check("fl_start", 64'(div_start), 64'd0);
      check("fl_valid", 64'(res_valid), 64'd0);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         if (res_valid || div_start) seen = 1'b1;
      end
      check("fl_quiet", 64'(seen), 64'd0);

      // DIVU 9/3 after flush, then hold without accept
      issue(1'b0, 32'd9, 32'd3);
      wait_res("post", 1'b1, drop, ubad);
      check("post_res", {result_hi, result_lo}, {32'd0, 32'd3});
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            inj_done = 1'b1;
            inj_res  = 64'hDEAD_BEEF_0BAD_F00D;
         end
         #1;
         check("hold_valid", 64'(res_valid), 64'd1);
         check("hold_stall", 64'(stall_req), 64'd1);
         check("hold_res", {result_hi, result_lo}, {32'd0, 32'd3});
         @(negedge clock);
         inj_done = 1'b0;
      end
      check("hold_res_end", {result_hi, result_lo}, {32'd0, 32'd3});
      accept("post");

      // Watchdog with a divider that never completes
      stub_dead = 1'b1;
      issue(1'b0, 32'd1, 32'd1);
      c = 0;
      while (!div_timeout && c < 200) begin
         if (c == int'(WDOG_CYCLES) - 1) check("wdog_early", 64'(div_timeout), 64'd0);
         @(negedge clock);
         c++;
      end
      check("wdog_cycles", 64'(c), 64'(WDOG_CYCLES));
      repeat (5) @(negedge clock);
      check("wdog_sticky", 64'(div_timeout), 64'd1);
      check("wdog_busy_start", 64'(div_start), 64'd1);
      check("wdog_busy_stall", 64'(stall_req), 64'd1);

      // Async reset mid-BUSY clears outputs without a clock edge
      #2;
      reset = 1'b0;
      #1;
      check_all_zero("arst");
      @(negedge clock);
      reset     = 1'b1;
      stub_dead = 1'b0;
      repeat (2) @(negedge clock);
      check("arst_tmo_after", 64'(div_timeout), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
